// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch (imem) and the load/store unit (dmem)
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   imem_req_i/addr_i             fetch request (held until imem_ready_o) and address
//   imem_rd_o/ready_o/err_o       fetch read data, completion pulse, timeout abort
//   dmem_req_i/we_i/be_i/addr_i/wd_i   data request (held until dmem_ready_o) and payload
//   dmem_rd_o/ready_o/err_o       data read data, completion pulse, timeout abort
//   mem_req_o/we_o/be_o/addr_o/wd_o    memory-side request
//   mem_rd_i/ready_i              memory read data, one-cycle completion pulse
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles without mem_ready_i before abort; 0 disables the watchdog
//   CNT_W           watchdog counter width, TIMEOUT_CYCLES < 2**CNT_W
//
// Macro RISCV_ARB_ROUND_ROBIN_EN: when both requests are pending, grant the one that did
// not win last time; otherwise data always wins.
module riscv_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_rd_o,
  output logic        imem_ready_o,
  output logic        imem_err_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wd_i,
  output logic [31:0] dmem_rd_o,
  output logic        dmem_ready_o,
  output logic        dmem_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);
`ifdef RISCV_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t r_state;
  logic r_last_d;
  logic [CNT_W-1:0] r_cnt;
  logic w_bi, w_bd, w_req, w_tmo, w_grant_d;
  always_comb begin
    w_bi = r_state == BUSY_I;
    w_bd = r_state == BUSY_D;
    w_req = (w_bi & imem_req_i) | (w_bd & dmem_req_i);
    // a ready arriving on the last watchdog cycle wins over the abort
    w_tmo = (TIMEOUT_CYCLES > 0) && w_req && !mem_ready_i && r_cnt == LIM;
    // with round robin, data yields only when fetch is also pending and data won last time
    w_grant_d = dmem_req_i && (!RR || !imem_req_i || !r_last_d);
  end
  assign mem_req_o    = w_req;
  assign mem_we_o     = w_bd & dmem_we_i;
  assign mem_be_o     = w_bd ? dmem_be_i : w_bi ? 4'hF : 4'h0;
  assign mem_addr_o   = w_bd ? dmem_addr_i : w_bi ? imem_addr_i : '0;
  assign mem_wd_o     = w_bd ? dmem_wd_i : '0;
  assign imem_ready_o = w_bi & (mem_ready_i | w_tmo);
  assign imem_err_o   = w_bi & w_tmo;
  assign imem_rd_o    = (w_bi & ~w_tmo) ? mem_rd_i : '0;
  assign dmem_ready_o = w_bd & (mem_ready_i | w_tmo);
  assign dmem_err_o   = w_bd & w_tmo;
  assign dmem_rd_o    = (w_bd & ~w_tmo) ? mem_rd_i : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == IDLE) begin
      r_state <= w_grant_d ? BUSY_D : imem_req_i ? BUSY_I : IDLE;
      r_cnt   <= '0;
    end else begin
      // a dropped request, a completion or an abort all return to IDLE
      if (!w_req || mem_ready_i || w_tmo) r_state <= IDLE;
      if (mem_ready_i) r_last_d <= w_bd;
      if (TIMEOUT_CYCLES > 0 && !mem_ready_i) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
